// File: rtl/uart_tx_byte_scheduler_pkg.sv
// uart_pkg: scheduler state encoding and launch watchdog length shared by the
// UART byte scheduler files.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} tx_sched_state_e;
   localparam int LAUNCH_WDOG = 4;
endpackage

// File: rtl/uart_tx_byte_scheduler_ring.sv
// byte_ring_buffer: circular store with wrap-bit pointers; the head entry is
// read combinationally so a pop can capture it in the same cycle.
module byte_ring_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DATA_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DATA_W-1:0]          din,
   input  logic                       pop,
   output logic [DATA_W-1:0]          dout,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       empty,
   output logic                       drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   logic [AW:0] wr_ptr, rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic wr_en, rd_en;
   assign full  = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
   assign empty = wr_ptr == rd_ptr;
   // A pop frees the slot the same cycle, so a full buffer still accepts.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign drop  = push && full && !pop;
   assign dout  = mem[rd_ptr[AW-1:0]];
   assign level = LW'(wr_ptr - rd_ptr);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_tx_byte_scheduler.sv
// uart_tx_byte_scheduler: buffers glitcher bytes and launches at most one byte
// per UART frame, with a post-frame gap and a watchdog on stalled launches.
module uart_tx_byte_scheduler
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DATA_W = 8,
   parameter int GAP_CLKS = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_dv,
   input  logic [DATA_W-1:0]          in_byte,
   input  logic                       tx_active,
   input  logic                       tx_done,
   output logic                       tx_dv,
   output logic [DATA_W-1:0]          tx_byte,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
);
   localparam int CNT_MAX = GAP_CLKS > LAUNCH_WDOG ? GAP_CLKS : LAUNCH_WDOG;
   localparam int CW = $clog2(CNT_MAX+1);
   tx_sched_state_e state;
   logic [CW-1:0] cnt;
   logic [DATA_W-1:0] head;
   logic pop, drop;
   assign pop = state == IDLE && !empty;
   byte_ring_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf (
      .clk(clk), .rst_n(rst_n), .push(in_dv), .din(in_byte), .pop(pop),
      .dout(head), .level(level), .full(full), .empty(empty), .drop(drop)
   );
   // cnt is shared: launch watchdog in LAUNCH, idle spacing in GAP.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         tx_dv    <= 1'b0;
         tx_byte  <= '0;
         overflow <= 1'b0;
      end else begin
         tx_dv <= pop;
         if (drop) overflow <= 1'b1;
         case (state)
            IDLE:
               if (pop) begin
                  tx_byte <= head;
                  cnt     <= '0;
                  state   <= LAUNCH;
               end
            LAUNCH:
               if (tx_done) begin
                  cnt   <= '0;
                  state <= GAP;
               end else if (tx_active) state <= BUSY;
               else if (cnt == CW'(LAUNCH_WDOG-1)) state <= IDLE;
               else cnt <= cnt + 1'b1;
            BUSY:
               if (tx_done) begin
                  cnt   <= '0;
                  state <= GAP;
               end
            GAP:
               if (cnt == CW'(GAP_CLKS-1)) state <= IDLE;
               else cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_tx_byte_scheduler.sv
// tb_uart_tx_byte_scheduler: directed bench with a queue-based reference model
// of the scheduler and a simple uart_tx responder.
module tb_uart_tx_byte_scheduler;
   localparam int DEPTH = 16;
   localparam int GAP_CLKS = 2;
   localparam int WDOG = 4;

   logic clk = 0, rst_n = 0, in_dv = 0, tx_active = 0, tx_done = 0, stall = 0;
   logic [7:0] in_byte = 0, tx_byte, b;
   logic tx_dv, full, empty, overflow;
   logic [4:0] level;

   int total = 0, bad = 0;
   logic [7:0] mq[$], emit[$], sent[$], exp3[$];
   int dv_cyc[$];
   logic m_dv = 0, m_ovf = 0, in_frame = 0, got_active = 0, pop_now, was_full;
   logic [7:0] m_byte = 0;
   int t = 0, ready_at = 0, frame_start = 0, ncyc = 0, last_done = 0, lvl_max = 0, ucnt = 0;
   logic done_seen = 0, dvs = 0;

   uart_tx_byte_scheduler #(.DEPTH(DEPTH), .DATA_W(8), .GAP_CLKS(GAP_CLKS)) dut (
      .clk(clk), .rst_n(rst_n), .in_dv(in_dv), .in_byte(in_byte),
      .tx_active(tx_active), .tx_done(tx_done), .tx_dv(tx_dv), .tx_byte(tx_byte),
      .level(level), .full(full), .empty(empty), .overflow(overflow)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] v);
      in_dv = 1;
      in_byte = v;
      tick();
      in_dv = 0;
   endtask

   task automatic drain(input int lim);
      int k = 0;
      while ((mq.size() != 0 || !empty) && k < lim) begin
         tick();
         k++;
      end
      chk("drain", 32'(k < lim), 1);
      repeat (20) tick();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_dv"}, 32'(tx_dv), 0);
      chk({tag, "_byte"}, 32'(tx_byte), 0);
      chk({tag, "_level"}, 32'(level), 0);
      chk({tag, "_empty"}, 32'(empty), 1);
      chk({tag, "_full"}, 32'(full), 0);
      chk({tag, "_ovf"}, 32'(overflow), 0);
   endtask

   // uart_tx responder: active one cycle after a launch, done ten cycles later.
   initial forever begin
      @(negedge clk);
      dvs = tx_dv;
      @(posedge clk);
      #1;
      tx_done = 0;
      if (!rst_n) begin
         tx_active = 0;
         dvs = 0;
      end else begin
         if (tx_active) begin
            ucnt++;
            if (ucnt == 10) begin
               tx_active = 0;
               tx_done = 1;
            end
         end
         if (dvs && !stall) begin
            tx_active = 1;
            ucnt = 0;
         end
      end
   end

   // Reference model: a byte queue plus the cycle at which the sender is next free.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mq.delete();
         m_dv = 0;
         m_byte = 0;
         m_ovf = 0;
         in_frame = 0;
         ready_at = 0;
      end else begin
         was_full = mq.size() == DEPTH;
         pop_now = !in_frame && t >= ready_at && mq.size() != 0;
         if (in_frame) begin
            if (tx_done) begin
               in_frame = 0;
               ready_at = t + 1 + GAP_CLKS;
            end else if (!got_active) begin
               if (tx_active) got_active = 1;
               else if (t - frame_start == WDOG - 1) begin
                  in_frame = 0;
                  ready_at = t + 1;
               end
            end
         end
         m_dv = pop_now;
         if (pop_now) begin
            m_byte = mq.pop_front();
            in_frame = 1;
            got_active = 0;
            frame_start = t + 1;
         end
         if (in_dv) begin
            if (!was_full || pop_now) mq.push_back(in_byte);
            else m_ovf = 1;
         end
         t++;
      end
   end

   // Per-cycle comparison against the model, plus launch/done bookkeeping.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         ncyc++;
         chk("tx_dv", 32'(tx_dv), 32'(m_dv));
         chk("tx_byte", 32'(tx_byte), 32'(m_byte));
         chk("level", 32'(level), 32'(mq.size()));
         chk("full", 32'(full), 32'(mq.size() == DEPTH));
         chk("empty", 32'(empty), 32'(mq.size() == 0));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         if (!rst_n) done_seen = 0;
         else begin
            if (tx_done) begin
               done_seen = 1;
               last_done = ncyc;
            end
            if (tx_dv) begin
               emit.push_back(tx_byte);
               dv_cyc.push_back(ncyc);
               if (done_seen) begin
                  chk("launch_gap", 32'(ncyc - last_done > GAP_CLKS), 1);
                  done_seen = 0;
               end
            end
            if (int'(level) > lvl_max) lvl_max = int'(level);
         end
      end
   end

   initial begin
      repeat (3) tick();
      chk_reset_outputs("rst");
      rst_n = 1;
      repeat (2) tick();

      // single byte: launch two cycles after in_dv
      emit.delete();
      push(8'hA5);
      chk("t1_dv_n1", 32'(tx_dv), 0);
      tick();
      chk("t1_dv_n2", 32'(tx_dv), 1);
      chk("t1_byte", 32'(tx_byte), 32'h A5);
      chk("t1_level", 32'(level), 0);
      repeat (30) tick();
      chk("t1_frames", 32'(emit.size()), 1);

      // burst of 16, then fill to DEPTH and push on the pop cycle
      emit.delete();
      for (int i = 0; i < 16; i++) push(8'(i));
      chk("t2_level15", 32'(level), 15);
      chk("t2_full", 32'(full), 0);
      chk("t2_ovf", 32'(overflow), 0);
      tick();
      push(8'h10);
      push(8'h11);
      chk("t4_level16", 32'(level), 16);
      chk("t4_full", 32'(full), 1);
      repeat (12) tick();
      push(8'h12);
      chk("t4_level_hold", 32'(level), 16);
      chk("t4_ovf", 32'(overflow), 0);
      chk("t4_dv", 32'(tx_dv), 1);
      chk("t4_byte", 32'(tx_byte), 32'h02);
      drain(600);
      chk("t2_count", 32'(emit.size()), 19);
      foreach (emit[i]) chk("t2_order", 32'(emit[i]), 32'(i));

      // stalled uart during a 20-byte burst
      emit.delete();
      dv_cyc.delete();
      push(8'h40);
      tick();
      tick();
      for (int i = 0; i < 20; i++) begin
         if (i == 2) stall = 1;
         push(8'(8'h80 + i));
      end
      chk("t3_ovf", 32'(overflow), 1);
      chk("t3_launches", 32'(dv_cyc.size()), 3);
      if (dv_cyc.size() >= 3) chk("t3_wdog", 32'(dv_cyc[2] - dv_cyc[1]), 32'(WDOG + 1));
      repeat (10) tick();
      stall = 0;
      drain(800);
      exp3 = {8'h40};
      for (int i = 0; i <= 16; i++) exp3.push_back(8'(8'h80 + i));
      exp3.push_back(8'h92);
      chk("t3_count", 32'(emit.size()), 32'(exp3.size()));
      foreach (exp3[i]) if (i < emit.size()) chk("t3_order", 32'(emit[i]), 32'(exp3[i]));

      // reset mid-frame with five bytes buffered
      for (int i = 0; i < 6; i++) push(8'(8'h21 + i));
      chk("t5_level", 32'(level), 5);
      rst_n = 0;
      dv_cyc.delete();
      #1;
      chk_reset_outputs("t5");
      repeat (3) tick();
      rst_n = 1;
      repeat (10) tick();
      chk("t5_no_dv", 32'(dv_cyc.size()), 0);
      push(8'h5A);
      tick();
      chk("t5_dv", 32'(tx_dv), 1);
      chk("t5_byte", 32'(tx_byte), 32'h5A);
      drain(100);

      // 40 bytes with random spacing across several pointer wraps
      emit.delete();
      sent.delete();
      lvl_max = 0;
      for (int i = 0; i < 40; i++) begin
         int k = 0;
         repeat ($urandom_range(0, 12)) tick();
         while (mq.size() >= DEPTH - 1 && k < 1000) begin
            tick();
            k++;
         end
         b = 8'($urandom);
         sent.push_back(b);
         push(b);
      end
      drain(1000);
      chk("t6_count", 32'(emit.size()), 40);
      foreach (sent[i]) if (i < emit.size()) chk("t6_order", 32'(emit[i]), 32'(sent[i]));
      chk("t6_ovf", 32'(overflow), 0);
      chk("t6_lvl_max", 32'(lvl_max <= DEPTH), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
